// File: rtl/timer_intr_unit_pkg.sv
// Shared constants for the machine timer/software interrupt unit: register offsets,
// trap cause codes and the request FSM encoding.
package timer_intr_unit_pkg;

  localparam logic [2:0] TIM_MTIME_LO = 3'd0;
  localparam logic [2:0] TIM_MTIME_HI = 3'd1;
  localparam logic [2:0] TIM_CMP_LO   = 3'd2;
  localparam logic [2:0] TIM_CMP_HI   = 3'd3;
  localparam logic [2:0] TIM_MSIP     = 3'd4;
  localparam logic [2:0] TIM_PRESCALE = 3'd5;

  localparam logic [31:0] CAUSE_M_TIMER = 32'h8000_0007;
  localparam logic [31:0] CAUSE_M_SOFT  = 32'h8000_0003;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PEND    = 2'b01,
    ST_SERVICE = 2'b10
  } tim_state_e;

endpackage

// File: rtl/timer_intr_unit_if.sv
// Memory-mapped data-bus port of the timer unit; master is the core LSU, slave is the timer.
// Reads are combinational, writes land on the clock edge ending the access; no stalls.
interface timer_intr_unit_if;
  logic        sel;
  logic [4:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, output addr, output we, output wdata, input rdata);
  modport slave  (input sel, input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/timer_intr_unit_mtime_counter.sv
// Prescaled 64-bit mtime counter with half-word write port; writes take effect on the next edge.
// A write to either half drops that cycle's increment; writing prescale restarts the divider.
module mtime_counter #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  lo_we_i,
  input  logic                  hi_we_i,
  input  logic                  ps_we_i,
  input  logic [31:0]           wdata_i,
  output logic [63:0]           mtime_o,
  output logic [PRESCALE_W-1:0] prescale_o
);

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [63:0]           mtime_q, mtime_d;
  logic                  tick;

  always_comb begin
    tick       = (pcnt_q == prescale_q);
    pcnt_d     = tick ? '0 : pcnt_q + 1'b1;
    prescale_d = prescale_q;
    if (ps_we_i) begin
      prescale_d = wdata_i[PRESCALE_W-1:0];
      pcnt_d     = '0;
    end

    // The written half wins outright; the other half keeps its old value (no carry).
    mtime_d = mtime_q + 64'(tick);
    if (lo_we_i) begin
      mtime_d = {mtime_q[63:32], wdata_i};
    end else if (hi_we_i) begin
      mtime_d = {wdata_i, mtime_q[31:0]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pcnt_q     <= '0;
      prescale_q <= '0;
      mtime_q    <= '0;
    end else begin
      pcnt_q     <= pcnt_d;
      prescale_q <= prescale_d;
      mtime_q    <= mtime_d;
    end
  end

  assign mtime_o    = mtime_q;
  assign prescale_o = prescale_q;

endmodule

// File: rtl/timer_intr_unit.sv
// Machine timer + software interrupt source; one registered request per event, 1-cycle latency.
// The request holds in PEND until taken or withdrawn, and re-arms only after mret.
module timer_intr_unit
  import timer_intr_unit_pkg::*;
#(
  parameter int          PRESCALE_W = 8,
  parameter logic [63:0] CMP_RESET  = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  timer_intr_unit_if.slave         bus,
  input  logic                     mie_i,
  input  logic                     mtie_i,
  input  logic                     msie_i,
  input  logic                     int_taken_i,
  input  logic                     mret_i,
  output logic                     interrupt_o,
  output logic [31:0]              int_cause_o,
  output logic                     timer_pend_o
);

  logic [63:0]           mtime;
  logic [PRESCALE_W-1:0] prescale;
  logic [63:0]           cmp_q, cmp_d;
  logic                  msip_q, msip_d;
  logic                  wr_en;
  logic [2:0]            reg_sel;
  logic                  src_t, src_s, src;
  tim_state_e            state_q;
  logic                  interrupt_q;
  logic [31:0]           cause_q;
  logic                  unused_addr;

  assign reg_sel     = bus.addr[4:2];
  assign wr_en       = bus.sel & bus.we;
  assign unused_addr = ^bus.addr[1:0];

  mtime_counter #(
    .PRESCALE_W (PRESCALE_W)
  ) u_mtime (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .lo_we_i    (wr_en && (reg_sel == TIM_MTIME_LO)),
    .hi_we_i    (wr_en && (reg_sel == TIM_MTIME_HI)),
    .ps_we_i    (wr_en && (reg_sel == TIM_PRESCALE)),
    .wdata_i    (bus.wdata),
    .mtime_o    (mtime),
    .prescale_o (prescale)
  );

  always_comb begin
    cmp_d  = cmp_q;
    msip_d = msip_q;
    if (wr_en) begin
      case (reg_sel)
        TIM_CMP_LO: cmp_d  = {cmp_q[63:32], bus.wdata};
        TIM_CMP_HI: cmp_d  = {bus.wdata, cmp_q[31:0]};
        TIM_MSIP:   msip_d = bus.wdata[0];
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cmp_q  <= CMP_RESET;
      msip_q <= 1'b0;
    end else begin
      cmp_q  <= cmp_d;
      msip_q <= msip_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    case (reg_sel)
      TIM_MTIME_LO: bus.rdata = mtime[31:0];
      TIM_MTIME_HI: bus.rdata = mtime[63:32];
      TIM_CMP_LO:   bus.rdata = cmp_q[31:0];
      TIM_CMP_HI:   bus.rdata = cmp_q[63:32];
      TIM_MSIP:     bus.rdata = {31'd0, msip_q};
      TIM_PRESCALE: bus.rdata = 32'(prescale);
      default:      bus.rdata = '0;
    endcase
  end

  assign timer_pend_o = (mtime >= cmp_q);
  assign src_t        = timer_pend_o & mtie_i;
  assign src_s        = msip_q & msie_i;
  assign src          = (src_t | src_s) & mie_i;

  // Software wins the cause when both sources fire; cause is frozen once in PEND.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      interrupt_q <= 1'b0;
      cause_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (src) begin
            state_q     <= ST_PEND;
            interrupt_q <= 1'b1;
            cause_q     <= src_s ? CAUSE_M_SOFT : CAUSE_M_TIMER;
          end
        end
        ST_PEND: begin
          if (int_taken_i) begin
            state_q     <= ST_SERVICE;
            interrupt_q <= 1'b0;
          end else if (!src) begin
            state_q     <= ST_IDLE;
            interrupt_q <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (mret_i) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          interrupt_q <= 1'b0;
        end
      endcase
    end
  end

  assign interrupt_o = interrupt_q;
  assign int_cause_o = cause_q;

endmodule

// File: tb/tb_timer_intr_unit.sv
// Directed bench for timer_intr_unit: register map, prescaler, handshake FSM, priority and reset.
module tb_timer_intr_unit;
  import timer_intr_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        mie, mtie, msie, int_taken, mret;
  logic        interrupt;
  logic [31:0] int_cause;
  logic        timer_pend;
  logic [31:0] d;
  int          total;
  int          bad;
  bit          found;

  timer_intr_unit_if bus ();

  timer_intr_unit #(
    .PRESCALE_W (8),
    .CMP_RESET  (64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bus          (bus),
    .mie_i        (mie),
    .mtie_i       (mtie),
    .msie_i       (msie),
    .int_taken_i  (int_taken),
    .mret_i       (mret),
    .interrupt_o  (interrupt),
    .int_cause_o  (int_cause),
    .timer_pend_o (timer_pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge, returns at the next negedge.
  task automatic wr(input logic [2:0] r, input logic [31:0] v);
    bus.sel   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = {r, 2'b00};
    bus.wdata = v;
    @(negedge clk);
    bus.sel   = 1'b0;
    bus.we    = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] v);
    bus.sel  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    v = bus.rdata;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    mie = 1'b0; mtie = 1'b0; msie = 1'b0; int_taken = 1'b0; mret = 1'b0;
    bus.sel = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    rd({TIM_MTIME_LO, 2'b00}, d); chk("rst_mtime_lo", d, 32'h0);
    rd({TIM_MTIME_HI, 2'b00}, d); chk("rst_mtime_hi", d, 32'h0);
    rd({TIM_CMP_LO, 2'b00}, d);   chk("rst_cmp_lo", d, 32'hFFFF_FFFF);
    rd({TIM_CMP_HI, 2'b11}, d);   chk("rst_cmp_hi", d, 32'hFFFF_FFFF);
    chk("rst_interrupt", 32'(interrupt), 32'd0);
    chk("rst_cause", int_cause, 32'h0);
    chk("rst_pend", 32'(timer_pend), 32'd0);
    @(negedge clk);
    rd({TIM_MSIP, 2'b00}, d);     chk("rst_msip", d, 32'h0);
    rd({TIM_PRESCALE, 2'b00}, d); chk("rst_prescale", d, 32'h0);
    rd(5'd28, d);                 chk("unmapped_rd", d, 32'h0);

    // Prescale 3: clear mtime on a divider tick edge, then 40 edges give 10 increments
    wr(TIM_PRESCALE, 32'd3);
    rd({TIM_PRESCALE, 2'b00}, d); chk("prescale_rd", d, 32'd3);
    repeat (3) @(negedge clk);
    wr(TIM_MTIME_LO, 32'd0);
    repeat (40) @(negedge clk);
    rd({TIM_MTIME_LO, 2'b00}, d); chk("prescale_count", d, 32'd10);

    // Low-half rollover with prescale 0; the write cycle's increment is dropped
    wr(TIM_PRESCALE, 32'd0);
    wr(TIM_MTIME_HI, 32'd0);
    wr(TIM_MTIME_LO, 32'hFFFF_FFFF);
    rd({TIM_MTIME_LO, 2'b00}, d); chk("wr_lo_val", d, 32'hFFFF_FFFF);
    rd({TIM_MTIME_HI, 2'b00}, d); chk("wr_lo_hi", d, 32'h0);
    @(negedge clk);
    rd({TIM_MTIME_LO, 2'b00}, d); chk("roll_lo", d, 32'h0);
    rd({TIM_MTIME_HI, 2'b00}, d); chk("roll_hi", d, 32'h1);

    // Timer handshake with mtimecmp = 20
    wr(TIM_MTIME_HI, 32'd0);
    wr(TIM_MTIME_LO, 32'd0);
    wr(TIM_CMP_LO, 32'd20);
    wr(TIM_CMP_HI, 32'd0);
    chk("pend_early", 32'(timer_pend), 32'd0);
    mie = 1'b1; mtie = 1'b1; msie = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (timer_pend) found = 1'b1;
    end
    chk("pend_found", 32'(found), 32'd1);
    rd({TIM_MTIME_LO, 2'b00}, d); chk("pend_at_20", d, 32'd20);
    chk("irq_not_yet", 32'(interrupt), 32'd0);
    @(negedge clk);
    chk("irq_timer", 32'(interrupt), 32'd1);
    chk("cause_timer", int_cause, 32'h8000_0007);
    int_taken = 1'b1;
    @(negedge clk);
    int_taken = 1'b0;
    chk("taken_drop", 32'(interrupt), 32'd0);
    repeat (3) @(negedge clk);
    chk("service_hold", 32'(interrupt), 32'd0);
    mret = 1'b1;
    @(negedge clk);
    mret = 1'b0;
    chk("rearm_m1", 32'(interrupt), 32'd0);
    @(negedge clk);
    chk("rearm_m2", 32'(interrupt), 32'd1);

    // Priority and global gating
    int_taken = 1'b1;
    @(negedge clk);
    int_taken = 1'b0;
    mie  = 1'b0;
    mret = 1'b1;
    @(negedge clk);
    mret = 1'b0;
    wr(TIM_MSIP, 32'd1);
    repeat (2) @(negedge clk);
    chk("mie_gate", 32'(interrupt), 32'd0);
    mie = 1'b1;
    @(negedge clk);
    chk("irq_soft", 32'(interrupt), 32'd1);
    chk("cause_soft", int_cause, 32'h8000_0003);
    chk("both_pend", 32'(timer_pend), 32'd1);

    // Withdrawal: only msip keeps PEND alive, then it is cleared
    wr(TIM_CMP_HI, 32'hFFFF_FFFF);
    chk("pend_cleared", 32'(timer_pend), 32'd0);
    chk("pend_still_irq", 32'(interrupt), 32'd1);
    wr(TIM_MSIP, 32'd0);
    @(negedge clk);
    chk("withdraw", 32'(interrupt), 32'd0);
    wr(TIM_MSIP, 32'd1);
    @(negedge clk);
    chk("idle_reraise", 32'(interrupt), 32'd1);

    // Simultaneous int_taken and mret in PEND: taken wins
    int_taken = 1'b1;
    mret      = 1'b1;
    @(negedge clk);
    int_taken = 1'b0;
    mret      = 1'b0;
    chk("simul_drop", 32'(interrupt), 32'd0);
    repeat (3) @(negedge clk);
    chk("simul_service", 32'(interrupt), 32'd0);

    // Reset from SERVICE
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_interrupt", 32'(interrupt), 32'd0);
    chk("rst2_cause", int_cause, 32'h0);
    chk("rst2_pend", 32'(timer_pend), 32'd0);
    rd({TIM_MTIME_LO, 2'b00}, d); chk("rst2_mtime", d, 32'h0);
    rd({TIM_MSIP, 2'b00}, d);     chk("rst2_msip", d, 32'h0);
    rd({TIM_CMP_HI, 2'b00}, d);   chk("rst2_cmp_hi", d, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("rst2_idle_quiet", 32'(interrupt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
